// File: rtl/my_sys_mem_pattern_tester_if.sv
// Avalon-MM bus between the pattern tester (master) and on-chip memory port s1 (slave).
interface my_sys_mem_pattern_tester_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] address;
    logic              clken;
    logic              chipselect;
    logic              write;
    logic [15:0]       writedata;
    logic [1:0]        byteenable;
    logic [15:0]       readdata;

    modport master (
        output address, clken, chipselect, write, writedata, byteenable,
        input  readdata
    );

    modport slave (
        input  address, clken, chipselect, write, writedata, byteenable,
        output readdata
    );
endinterface

// File: rtl/my_sys_mem_pattern_tester.sv
// Memory pattern self-test: fills an address window with an LFSR sequence,
// reads it back through a fixed-latency port and reports pass/fail, the
// number of mismatching words and the first failing address.
module my_sys_mem_pattern_tester #(
    parameter int          ADDR_W = 10,
    parameter int          RD_LAT = 1,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [ADDR_W-1:0]          end_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ADDR_W:0]            err_count,
    output logic [ADDR_W-1:0]          first_err_addr,
    my_sys_mem_pattern_tester_if.master mem
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] cnt;
    logic [15:0]       lfsr;

    // Read-compare line: entry k describes the read issued k+1 edges ago.
    logic              line_v [RD_LAT];
    logic [ADDR_W-1:0] line_a [RD_LAT];
    logic [15:0]       line_e [RD_LAT];

    logic              go;
    logic              stop;
    logic              last;
    logic              finish;
    logic              mismatch;
    logic [ADDR_W:0]   err_next;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Control decode and the error count including this edge's compare.
    always_comb begin
        go       = (state == ST_IDLE) && start;
        stop     = (state != ST_IDLE) && abort;
        last     = (cnt == '0);
        finish   = (state == ST_DRAIN) && last;
        mismatch = line_v[RD_LAT-1] && (mem.readdata != line_e[RD_LAT-1]);
        err_next = err_count;
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + 1'b1;
        end
    end

    // Sequencer: cnt holds words remaining after the current one, then drain cycles left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            addr  <= '0;
            base  <= '0;
            span  <= '0;
            cnt   <= '0;
            lfsr  <= SEED;
        end else if (stop) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WRITE;
                        addr  <= start_addr;
                        base  <= start_addr;
                        span  <= end_addr - start_addr;
                        cnt   <= end_addr - start_addr;
                        lfsr  <= SEED;
                    end
                end
                ST_WRITE: begin
                    if (last) begin
                        state <= ST_READ;
                        addr  <= base;
                        cnt   <= span;
                        lfsr  <= SEED;
                    end else begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt - 1'b1;
                        lfsr <= lfsr_next(lfsr);
                    end
                end
                ST_READ: begin
                    if (last) begin
                        state <= ST_DRAIN;
                        cnt   <= ADDR_W'(RD_LAT - 1);
                    end else begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt - 1'b1;
                        lfsr <= lfsr_next(lfsr);
                    end
                end
                ST_DRAIN: begin
                    if (last) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift issued reads toward the compare point; abort empties the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                line_v[i] <= 1'b0;
                line_a[i] <= '0;
                line_e[i] <= '0;
            end
        end else begin
            line_v[0] <= (state == ST_READ) && !stop;
            line_a[0] <= addr;
            line_e[0] <= lfsr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                line_v[i] <= line_v[i-1] && !stop;
                line_a[i] <= line_a[i-1];
                line_e[i] <= line_e[i-1];
            end
        end
    end

    // Result bookkeeping: clear on start, accumulate mismatches, publish on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                err_count      <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end else if (stop) begin
                pass <= 1'b0;
            end else begin
                if (mismatch) begin
                    err_count <= err_next;
                    if (err_count == '0) begin
                        first_err_addr <= line_a[RD_LAT-1];
                    end
                end
                if (finish) begin
                    done <= 1'b1;
                    pass <= (err_next == '0);
                end
            end
        end
    end

    // Bus drive; every output is zero while idle or in reset except the held address.
    always_comb begin
        busy           = (state != ST_IDLE);
        mem.clken      = busy;
        mem.chipselect = (state == ST_WRITE) || (state == ST_READ);
        mem.write      = (state == ST_WRITE);
        mem.address    = addr;
        mem.writedata  = mem.write ? lfsr : '0;
        mem.byteenable = mem.chipselect ? 2'b11 : 2'b00;
    end

endmodule

// File: tb/tb_my_sys_mem_pattern_tester.sv
// Self-checking bench: two testers (read latency 1 and 3) on behavioural memories
// with selectable read faults, compared against a cycle timeline model.
module tb_my_sys_mem_pattern_tester;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [9:0] sa_in;
    logic [9:0] ea_in;
    int         sel;
    int         fault_mode;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    // Read-path fault injection applied by the memory models.
    function automatic logic [15:0] corrupt(input logic [15:0] d, input logic [9:0] a);
        case (fault_mode)
            1:       return (a == 10'd2) ? (d ^ 16'h0001) : d;
            2:       return 16'h0000;
            3:       return a[0] ? (d ^ 16'h0100) : d;
            default: return d;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 1 : 3;
        logic        busy, done, pass;
        logic [10:0] err_count;
        logic [9:0]  first_err_addr;
        logic [9:0]  address;
        logic        clken, chipselect, write;
        logic [15:0] writedata;
        logic [1:0]  byteenable;
        logic [15:0] ram [0:1023];
        logic [15:0] rd_pipe [L];

        my_sys_mem_pattern_tester_if #(.ADDR_W(10)) bus ();

        my_sys_mem_pattern_tester #(.ADDR_W(10), .RD_LAT(L), .SEED(16'hACE1)) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start && (sel == g)),
            .abort          (abort && (sel == g)),
            .start_addr     (sa_in),
            .end_addr       (ea_in),
            .busy           (busy),
            .done           (done),
            .pass           (pass),
            .err_count      (err_count),
            .first_err_addr (first_err_addr),
            .mem            (bus)
        );

        assign address    = bus.address;
        assign clken      = bus.clken;
        assign chipselect = bus.chipselect;
        assign write      = bus.write;
        assign writedata  = bus.writedata;
        assign byteenable = bus.byteenable;
        assign bus.readdata = rd_pipe[L-1];

        always @(posedge clk) begin
            if (bus.clken && bus.chipselect && bus.write)
                ram[bus.address] <= bus.writedata;
            if (bus.clken && bus.chipselect && !bus.write)
                rd_pipe[0] <= corrupt(ram[bus.address], bus.address);
            for (int i = 1; i < L; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    logic        o_busy, o_done, o_pass, o_clken, o_cs, o_wr;
    logic [10:0] o_err;
    logic [9:0]  o_first, o_addr;
    logic [15:0] o_wd;
    logic [1:0]  o_be;

    always_comb begin
        if (sel == 1) begin
            o_busy = u[1].busy;  o_done = u[1].done;  o_pass = u[1].pass;
            o_err = u[1].err_count;  o_first = u[1].first_err_addr;
            o_addr = u[1].address;  o_clken = u[1].clken;  o_cs = u[1].chipselect;
            o_wr = u[1].write;  o_wd = u[1].writedata;  o_be = u[1].byteenable;
        end else begin
            o_busy = u[0].busy;  o_done = u[0].done;  o_pass = u[0].pass;
            o_err = u[0].err_count;  o_first = u[0].first_err_addr;
            o_addr = u[0].address;  o_clken = u[0].clken;  o_cs = u[0].chipselect;
            o_wr = u[0].write;  o_wd = u[0].writedata;  o_be = u[0].byteenable;
        end
    end

    // One full test on instance lsel; the reference is a per-cycle timeline derived
    // from the word list, plus an error tally from the fault model.
    task automatic run(input int lsel, input logic [9:0] sa, input logic [9:0] ea,
                       input int fmode, input int abort_at, input int restart_at,
                       input string name);
        int          n, lat, nerr, k_last;
        logic [9:0]  span, a, first_a, e_ad;
        logic [15:0] v, e_wd, got;
        logic [10:0] exp_err;
        logic [15:0] exp_d [$];
        logic [9:0]  exp_a [$];
        logic        e_cs, e_wr, e_busy, e_done, ok, seen_done;

        sel = lsel; fault_mode = fmode; sa_in = sa; ea_in = ea;
        start = 1'b0; abort = 1'b0;
        lat  = (lsel == 1) ? 3 : 1;
        span = ea - sa;
        n    = int'(span) + 1;
        v = 16'hACE1; a = sa; nerr = 0; first_a = '0;
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(v);
            exp_a.push_back(a);
            if (corrupt(v, a) != v) begin
                if (nerr == 0) first_a = a;
                nerr++;
            end
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
            a = a + 10'd1;
        end
        exp_err = (nerr > 2047) ? 11'h7FF : 11'(nerr);
        k_last  = 2 * n + lat + 2;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= k_last; k++) begin
            start = (k == restart_at);
            e_cs = 1'b0; e_wr = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_ad = '0; e_wd = '0;
            if (k <= n) begin
                e_cs = 1'b1; e_wr = 1'b1; e_ad = exp_a[k-1]; e_wd = exp_d[k-1];
            end else if (k <= 2 * n) begin
                e_cs = 1'b1; e_ad = exp_a[k-n-1];
            end else if (k == 2 * n + lat + 1) begin
                e_busy = 1'b0; e_done = 1'b1;
            end else if (k == 2 * n + lat + 2) begin
                e_busy = 1'b0;
            end
            vectors++;
            ok = (o_cs === e_cs) && (o_wr === e_wr) && (o_busy === e_busy) &&
                 (o_clken === e_busy) && (o_done === e_done) &&
                 (o_be === (e_cs ? 2'b11 : 2'b00));
            if (e_cs && (o_addr !== e_ad)) ok = 1'b0;
            if (e_wr && (o_wd !== e_wd)) ok = 1'b0;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s bus k=%0d: got cs=%b wr=%b addr=%h wd=%h busy=%b clken=%b done=%b be=%b; want cs=%b wr=%b addr=%h wd=%h busy=%b done=%b",
                         name, k, o_cs, o_wr, o_addr, o_wd, o_busy, o_clken, o_done, o_be,
                         e_cs, e_wr, e_ad, e_wd, e_busy, e_done);
            end
            if (k == 2 * n + lat + 1) begin
                vectors++;
                if ((o_pass !== (nerr == 0)) || (o_err !== exp_err) ||
                    ((nerr != 0) && (o_first !== first_a))) begin
                    miscompares++;
                    $display("FAIL %s result: got pass=%b err=%h first=%h; want pass=%b err=%h first=%h",
                             name, o_pass, o_err, o_first, (nerr == 0), exp_err, first_a);
                end
            end
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                vectors++;
                if ((o_busy !== 1'b0) || (o_cs !== 1'b0) || (o_pass !== 1'b0) || (o_done !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL %s abort: got busy=%b cs=%b pass=%b done=%b; want all 0",
                             name, o_busy, o_cs, o_pass, o_done);
                end
                seen_done = 1'b0;
                for (int j = 0; j < 2 * lat + 4; j++) begin
                    @(negedge clk);
                    if (o_done !== 1'b0) seen_done = 1'b1;
                end
                vectors++;
                if (seen_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s abort_no_done: got done pulse=%b; want 0", name, seen_done);
                end
                return;
            end
            if (k < k_last) @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            got = (lsel == 1) ? u[1].ram[exp_a[i]] : u[0].ram[exp_a[i]];
            vectors++;
            if (got !== exp_d[i]) begin
                miscompares++;
                $display("FAIL %s ram[%h]: got %h; want %h", name, exp_a[i], got, exp_d[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            vectors++;
            if ({o_busy, o_done, o_pass, o_clken, o_cs, o_wr, o_err, o_first, o_addr, o_wd, o_be} !== '0) begin
                miscompares++;
                $display("FAIL reset inst%0d: got busy=%b done=%b pass=%b err=%h first=%h addr=%h cs=%b wr=%b wd=%h be=%b; want all 0",
                         s, o_busy, o_done, o_pass, o_err, o_first, o_addr, o_cs, o_wr, o_wd, o_be);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        sel = 0;
    endtask

    task automatic test_basic();
        run(0, 10'h000, 10'h003, 0, 0, 0, "basic");
    endtask

    task automatic test_bitflip();
        run(0, 10'h000, 10'h003, 1, 0, 0, "bitflip");
    endtask

    task automatic test_wrap();
        run(0, 10'h3FE, 10'h001, 0, 0, 0, "wrap");
    endtask

    task automatic test_latency3();
        run(1, 10'h010, 10'h010, 0, 0, 0, "lat3_single");
    endtask

    task automatic test_abort();
        run(0, 10'h000, 10'h007, 0, 11, 0, "abort_read");
        run(0, 10'h000, 10'h003, 0, 0, 0, "after_abort");
    endtask

    task automatic test_stuck_full();
        run(0, 10'h000, 10'h3FF, 2, 0, 5, "stuck0_full");
    endtask

    task automatic test_reset_mid_write();
        sel = 0; fault_mode = 0; sa_in = 10'h020; ea_in = 10'h05F;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ((o_busy !== 1'b1) || (o_wr !== 1'b1)) begin
            miscompares++;
            $display("FAIL midwrite_pre: got busy=%b wr=%b; want 1 1", o_busy, o_wr);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({o_busy, o_done, o_pass, o_clken, o_cs, o_wr, o_err, o_first, o_addr, o_wd, o_be} !== '0) begin
            miscompares++;
            $display("FAIL midwrite_reset: got busy=%b cs=%b wr=%b addr=%h wd=%h be=%b err=%h; want all 0",
                     o_busy, o_cs, o_wr, o_addr, o_wd, o_be, o_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [9:0] sa;
        for (int it = 0; it < 8; it++) begin
            sa = 10'($urandom);
            run($urandom_range(0, 1), sa, sa + 10'($urandom_range(0, 40)),
                $urandom_range(0, 3), 0, 0, "random");
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        sel = 0; fault_mode = 0; sa_in = '0; ea_in = '0;
        test_reset();
        test_basic();
        test_bitflip();
        test_wrap();
        test_latency3();
        test_abort();
        test_stuck_full();
        test_reset_mid_write();
        test_basic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
